// File: rtl/clk_meas_pkg.sv
// Shared types and default constants for the clock period meter.
package clk_meas_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        MEASURE,
        LOST
    } meas_state_e;

    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_TIMEOUT     = 1000;
    localparam int unsigned DEF_TOL         = 0;
    localparam int unsigned DEF_LOCK_CNT    = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level, plus rising-edge detect
// on the synchronised output.
module sync_edge_det
    import clk_meas_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Shift the raw input through the chain; remember last synchronised level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock in system-clock
// cycles, tracks lock across consecutive periods and flags loss of edges.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned TOL         = DEF_TOL,
    parameter int unsigned LOCK_CNT    = DEF_LOCK_CNT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic             en,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             lost
);

    localparam int unsigned MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   TOL_C     = (CNT_W + 1)'(TOL);
    localparam logic [MW-1:0]    LOCK_TGT  = MW'(LOCK_CNT - 1);
    localparam logic [MW-1:0]    M_ONE     = MW'(1);

    logic level, rise;

    meas_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             lost_q, lost_d;
    logic [MW-1:0]    match_q, match_d;
    logic             have_prev_q, have_prev_d;

    logic [CNT_W-1:0] cnt_inc, hcnt_inc, hcnt_reload;
    logic [CNT_W:0]   diff;
    logic             is_match;
    logic [MW-1:0]    match_nxt;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_in (clk_in),
        .level(level),
        .rise (rise)
    );

    // Saturating counter increments and period match evaluation.
    always_comb begin
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        hcnt_inc    = (level && hcnt_q != CNT_MAX) ? hcnt_q + CNT_ONE : hcnt_q;
        hcnt_reload = level ? CNT_ONE : '0;
        diff = ({1'b0, cnt_q} >= {1'b0, period_q}) ? ({1'b0, cnt_q} - {1'b0, period_q})
                                                   : ({1'b0, period_q} - {1'b0, cnt_q});
        // A saturated count only ever matches a saturated previous period.
        is_match = have_prev_q && (diff <= TOL_C) &&
                   !((cnt_q == CNT_MAX) && (period_q != CNT_MAX));
        if (!is_match) begin
            match_nxt = '0;
        end else if (match_q >= LOCK_TGT) begin
            match_nxt = match_q;
        end else begin
            match_nxt = match_q + M_ONE;
        end
    end

    // Next-state and output logic for the measurement FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_inc;
        hcnt_d      = hcnt_inc;
        period_d    = period_q;
        high_d      = high_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        match_d     = match_q;
        have_prev_d = have_prev_q;

        if (!en) begin
            state_d     = IDLE;
            cnt_d       = '0;
            hcnt_d      = '0;
            locked_d    = 1'b0;
            match_d     = '0;
            have_prev_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    hcnt_d  = '0;
                    state_d = WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_ONE;
                        hcnt_d  = hcnt_reload;
                    end else if (cnt_q >= TIMEOUT_C) begin
                        state_d = LOST;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        cnt_d       = CNT_ONE;
                        hcnt_d      = hcnt_reload;
                        period_d    = cnt_q;
                        high_d      = hcnt_q;
                        valid_d     = 1'b1;
                        have_prev_d = 1'b1;
                        match_d     = match_nxt;
                        locked_d    = is_match && (match_nxt >= LOCK_TGT) ||
                                      (LOCK_TGT == '0);
                    end else if (cnt_q >= TIMEOUT_C) begin
                        state_d     = LOST;
                        locked_d    = 1'b0;
                        match_d     = '0;
                        have_prev_d = 1'b0;
                    end
                end
                LOST: begin
                    locked_d    = 1'b0;
                    match_d     = '0;
                    have_prev_d = 1'b0;
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_ONE;
                        hcnt_d  = hcnt_reload;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        lost_d = (state_d == LOST);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            lost_q      <= 1'b0;
            match_q     <= '0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            lost_q      <= lost_d;
            match_q     <= match_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: two instances differing only in TOL.
module tb_clk_period_meter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n, clk_in, en;
    logic [W-1:0] p0, h0, p1, h1;
    logic         v0, l0, lo0, v1, l1, lo1;

    always #5 clk = ~clk;

    clk_period_meter #(
        .CNT_W(W), .SYNC_STAGES(2), .TIMEOUT(20), .TOL(0), .LOCK_CNT(2)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .clk_in(clk_in), .en(en),
        .period(p0), .high_time(h0), .valid(v0), .locked(l0), .lost(lo0)
    );

    clk_period_meter #(
        .CNT_W(W), .SYNC_STAGES(2), .TIMEOUT(20), .TOL(1), .LOCK_CNT(2)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .clk_in(clk_in), .en(en),
        .period(p1), .high_time(h1), .valid(v1), .locked(l1), .lost(lo1)
    );

    typedef struct packed {
        logic [W-1:0] p;
        logic [W-1:0] h;
        logic         l;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Record every valid pulse with the values visible alongside it.
    always @(negedge clk) begin
        if (v0) q0.push_back({p0, h0, l0});
        if (v1) q1.push_back({p1, h1, l1});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int hi, input int lo, input int n);
        repeat (n) begin
            clk_in = 1'b1;
            step(hi);
            clk_in = 1'b0;
            step(lo);
        end
    endtask

    task automatic restart();
        en = 1'b0;
        step(3);
        q0.delete();
        q1.delete();
        en = 1'b1;
        step(1);
    endtask

    task automatic chk_rec(input string tag, input bit use_q1, input int idx,
                           input int p, input int h, input int l);
        rec_t r;
        r = '1;
        if (!use_q1 && idx < q0.size()) r = q0[idx];
        if (use_q1 && idx < q1.size()) r = q1[idx];
        chk($sformatf("%s[%0d].period", tag, idx), r.p, p);
        chk($sformatf("%s[%0d].high", tag, idx), r.h, h);
        chk($sformatf("%s[%0d].locked", tag, idx), r.l, l);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".period"}, p0, 0);
        chk({tag, ".high"}, h0, 0);
        chk({tag, ".valid"}, v0, 0);
        chk({tag, ".locked"}, l0, 0);
        chk({tag, ".lost"}, lo0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        clk_in = 1'b0;
        #3;
        chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        en = 1'b1;
        step(2);
        q0.delete();
        q1.delete();

        // Steady 4-cycle clock, 50% duty.
        drive(2, 2, 6);
        step(4);
        chk("steady.count", q0.size(), 5);
        for (int i = 0; i < 5; i++) chk_rec("steady", 0, i, 4, 2, (i >= 1) ? 1 : 0);

        // 3 high / 7 low.
        restart();
        drive(3, 7, 4);
        step(4);
        chk("duty.count", q0.size(), 3);
        for (int i = 0; i < 3; i++) chk_rec("duty", 0, i, 10, 3, (i >= 1) ? 1 : 0);

        // Periods 8, 8, 9 against TOL=0 and TOL=1.
        restart();
        drive(4, 4, 2);
        drive(4, 5, 1);
        drive(4, 4, 1);
        step(4);
        chk("jit0.count", q0.size(), 3);
        chk("jit1.count", q1.size(), 3);
        chk_rec("jit0", 0, 0, 8, 4, 0);
        chk_rec("jit0", 0, 1, 8, 4, 1);
        chk_rec("jit0", 0, 2, 9, 4, 0);
        chk_rec("jit1", 1, 0, 8, 4, 0);
        chk_rec("jit1", 1, 1, 8, 4, 1);
        chk_rec("jit1", 1, 2, 9, 4, 1);

        // Loss: last reload is 3 edges after the final clk_in rise.
        restart();
        drive(2, 2, 4);
        chk("loss.count", q0.size(), 3);
        step(18);
        @(negedge clk);
        chk("loss.lost_before", lo0, 0);
        chk("loss.locked_before", l0, 1);
        @(negedge clk);
        chk("loss.lost_at20", lo0, 1);
        chk("loss.locked_at20", l0, 0);

        // Recovery: high 4 cycles, then two regular 4-cycle periods.
        @(posedge clk);
        #1;
        q0.delete();
        clk_in = 1'b1;
        step(2);
        @(negedge clk);
        chk("recov.lost_pre_rise", lo0, 1);
        @(negedge clk);
        chk("recov.lost_after_rise", lo0, 0);
        @(posedge clk);
        #1;
        clk_in = 1'b0;
        step(2);
        chk("recov.no_valid_first", q0.size(), 0);
        drive(2, 2, 2);
        step(4);
        chk("recov.count", q0.size(), 2);
        chk_rec("recov", 0, 0, 6, 4, 0);
        chk_rec("recov", 0, 1, 4, 2, 0);

        // Enable drop mid-period.
        restart();
        drive(2, 2, 4);
        chk("endrop.locked_before", l0, 1);
        en = 1'b0;
        step(1);
        chk("endrop.valid", v0, 0);
        chk("endrop.locked", l0, 0);
        chk("endrop.lost", lo0, 0);
        chk("endrop.period_hold", p0, 4);
        chk("endrop.high_hold", h0, 2);
        step(2);
        q0.delete();
        en = 1'b1;
        drive(2, 2, 3);
        step(4);
        chk("reen.count", q0.size(), 2);
        chk_rec("reen", 0, 0, 4, 2, 0);

        // en falling on the cycle a rise is acted on: no valid.
        restart();
        drive(2, 2, 3);
        clk_in = 1'b1;
        step(2);
        en = 1'b0;
        step(3);
        chk("enrise.no_valid", q0.size(), 2);

        // Asynchronous reset mid-measurement.
        restart();
        drive(2, 2, 3);
        clk_in = 1'b1;
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("areset");
        step(2);
        rst_n = 1'b1;
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
